// File: rtl/yuv_rgb_pkg.sv
// Shared types and helpers for the YUV 4:4:4 to RGB888 stream converter.
// Coefficient tables, byte offsets and the output clamp live here.
package yuv_rgb_pkg;

    typedef enum logic [1:0] {
        MODE_601L   = 2'd0,
        MODE_709L   = 2'd1,
        MODE_601F   = 2'd2,
        MODE_BYPASS = 2'd3
    } mode_e;

    typedef struct packed {
        logic [9:0] cy;
        logic [9:0] rv;
        logic [9:0] gu;
        logic [9:0] gv;
        logic [9:0] bu;
    } coef_t;

    localparam int U_LSB   = 0;
    localparam int Y_LSB   = 8;
    localparam int V_LSB   = 16;
    localparam int PAD_LSB = 24;

    localparam int OFF_W  = 11;
    localparam int PROD_W = 22;
    localparam int SUM_W  = 24;

    function automatic coef_t coef_of(input mode_e m);
        coef_t c;
        unique case (m)
            MODE_601L: c = '{10'd298, 10'd409, 10'd100, 10'd208, 10'd516};
            MODE_709L: c = '{10'd298, 10'd459, 10'd55, 10'd136, 10'd541};
            MODE_601F: c = '{10'd256, 10'd359, 10'd88, 10'd183, 10'd454};
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [SUM_W-1:0] x);
        logic [7:0] r;
        if (x[SUM_W-1]) begin
            r = 8'd0;
        end else if (|x[SUM_W-2:8]) begin
            r = 8'd255;
        end else begin
            r = x[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/nasti_stream_channel.sv
// NASTI stream link: valid/ready handshake carrying data, byte
// qualifiers, end-of-packet marker and routing side-band.
interface nasti_stream_channel #(
    parameter int N_DATA_BITS = 64,
    parameter int N_ID_BITS   = 1,
    parameter int N_DEST_BITS = 1,
    parameter int N_USER_BITS = 1
);
    logic                     t_valid;
    logic                     t_ready;
    logic [N_DATA_BITS-1:0]   t_data;
    logic [N_DATA_BITS/8-1:0] t_strb;
    logic [N_DATA_BITS/8-1:0] t_keep;
    logic                     t_last;
    logic [N_ID_BITS-1:0]     t_id;
    logic [N_DEST_BITS-1:0]   t_dest;
    logic [N_USER_BITS-1:0]   t_user;

    modport master (
        output t_valid, t_data, t_strb, t_keep,
        output t_last, t_id, t_dest, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_data, t_strb, t_keep,
        input  t_last, t_id, t_dest, t_user,
        output t_ready
    );
endinterface

// File: rtl/yuv_rgb_pixel_dp.sv
// One pixel's four-stage datapath: offset, multiply, sum/round/shift,
// clamp. Stage loads are driven by shared enables from the top.
module yuv_rgb_pixel_dp
    import yuv_rgb_pkg::*;
#(
    parameter int FRAC = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en0,
    input  logic        en1,
    input  logic        en2,
    input  logic        en3,
    input  mode_e       mode_in,
    input  mode_e       mode_s0,
    input  mode_e       mode_s2,
    input  logic [23:0] pix_in,
    output logic [31:0] pix_out
);

    localparam logic signed [SUM_W-1:0] RND = SUM_W'(1 << (FRAC-1));

    logic signed [OFF_W-1:0]  c_q, c_d, d_q, d_d, e_q, e_d;
    logic signed [PROD_W-1:0] pcy_q, pcy_d, prv_q, prv_d;
    logic signed [PROD_W-1:0] pgu_q, pgu_d, pgv_q, pgv_d;
    logic signed [PROD_W-1:0] pbu_q, pbu_d;
    logic signed [SUM_W-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic [23:0]              raw0_q, raw0_d, raw1_q, raw1_d;
    logic [23:0]              raw2_q, raw2_d;
    logic [31:0]              pix_q, pix_d;
    coef_t                    k;

    function automatic logic signed [PROD_W-1:0] mul(
        input logic [9:0]              kc,
        input logic signed [OFF_W-1:0] x
    );
        logic signed [PROD_W-1:0] kw, xw;
        kw = {{(PROD_W-10){1'b0}}, kc};
        xw = {{(PROD_W-OFF_W){x[OFF_W-1]}}, x};
        return kw * xw;
    endfunction

    function automatic logic signed [SUM_W-1:0] ext(
        input logic signed [PROD_W-1:0] p
    );
        return {{(SUM_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    assign k = coef_of(mode_s0);

    always_comb begin
        c_d    = c_q;
        d_d    = d_q;
        e_d    = e_q;
        raw0_d = raw0_q;
        pcy_d  = pcy_q;
        prv_d  = prv_q;
        pgu_d  = pgu_q;
        pgv_d  = pgv_q;
        pbu_d  = pbu_q;
        raw1_d = raw1_q;
        r_d    = r_q;
        g_d    = g_q;
        b_d    = b_q;
        raw2_d = raw2_q;
        pix_d  = pix_q;
        if (en0) begin
            c_d = $signed({3'b000, pix_in[Y_LSB +: 8]})
                - ((mode_in == MODE_601F) ? 11'sd0 : 11'sd16);
            d_d = $signed({3'b000, pix_in[U_LSB +: 8]}) - 11'sd128;
            e_d = $signed({3'b000, pix_in[V_LSB +: 8]}) - 11'sd128;
            raw0_d = pix_in;
        end
        if (en1) begin
            pcy_d  = mul(k.cy, c_q);
            prv_d  = mul(k.rv, e_q);
            pgu_d  = mul(k.gu, d_q);
            pgv_d  = mul(k.gv, e_q);
            pbu_d  = mul(k.bu, d_q);
            raw1_d = raw0_q;
        end
        if (en2) begin
            r_d = (ext(pcy_q) + ext(prv_q) + RND) >>> FRAC;
            g_d = (ext(pcy_q) - ext(pgu_q) - ext(pgv_q) + RND) >>> FRAC;
            b_d = (ext(pcy_q) + ext(pbu_q) + RND) >>> FRAC;
            raw2_d = raw1_q;
        end
        if (en3) begin
            // output byte order mirrors the input: R, G, B, zero pad
            if (mode_s2 == MODE_BYPASS) begin
                pix_d = {8'h00, raw2_q};
            end else begin
                pix_d = {8'h00, clamp8(b_q), clamp8(g_q), clamp8(r_q)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q    <= '0;
            d_q    <= '0;
            e_q    <= '0;
            raw0_q <= '0;
            pcy_q  <= '0;
            prv_q  <= '0;
            pgu_q  <= '0;
            pgv_q  <= '0;
            pbu_q  <= '0;
            raw1_q <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            raw2_q <= '0;
            pix_q  <= '0;
        end else begin
            c_q    <= c_d;
            d_q    <= d_d;
            e_q    <= e_d;
            raw0_q <= raw0_d;
            pcy_q  <= pcy_d;
            prv_q  <= prv_d;
            pgu_q  <= pgu_d;
            pgv_q  <= pgv_d;
            pbu_q  <= pbu_d;
            raw1_q <= raw1_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
            raw2_q <= raw2_d;
            pix_q  <= pix_d;
        end
    end

    assign pix_out = pix_q;

endmodule

// File: rtl/yuv444_rgb_stream_conv.sv
// Streaming YUV 4:4:4 to RGB888 converter: handshake, stage valids,
// t_last and per-beat matrix mode around PIXELS pixel datapaths.
module yuv444_rgb_stream_conv
    import yuv_rgb_pkg::*;
#(
    parameter int PIXELS = 2,
    parameter int FRAC   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    nasti_stream_channel.slave   src,
    nasti_stream_channel.master  dst,
    output logic                 busy
);

    logic  v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic  l0_q, l0_d, l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;
    mode_e m0_q, m0_d, m1_q, m1_d, m2_q, m2_d;
    mode_e mode_lat_q, mode_lat_d, beat_mode;
    logic  in_pkt_q, in_pkt_d;
    logic  adv0, adv1, adv2, adv3, src_rdy, acc;
    logic  unused_sig;
    logic [32*PIXELS-1:0] out_data;

    always_comb begin
        adv3      = v3_q && dst.t_ready;
        adv2      = v2_q && (!v3_q || adv3);
        adv1      = v1_q && (!v2_q || adv2);
        adv0      = v0_q && (!v1_q || adv1);
        src_rdy   = !v0_q || adv0;
        acc       = src.t_valid && src_rdy;
        // mode only takes effect on the first beat of a packet
        beat_mode = in_pkt_q ? mode_lat_q : mode_e'(mode);
    end

    always_comb begin
        v0_d       = src_rdy ? src.t_valid : v0_q;
        v1_d       = adv0 ? 1'b1 : (adv1 ? 1'b0 : v1_q);
        v2_d       = adv1 ? 1'b1 : (adv2 ? 1'b0 : v2_q);
        v3_d       = adv2 ? 1'b1 : (adv3 ? 1'b0 : v3_q);
        l0_d       = acc ? src.t_last : l0_q;
        l1_d       = adv0 ? l0_q : l1_q;
        l2_d       = adv1 ? l1_q : l2_q;
        l3_d       = adv2 ? l2_q : l3_q;
        m0_d       = acc ? beat_mode : m0_q;
        m1_d       = adv0 ? m0_q : m1_q;
        m2_d       = adv1 ? m1_q : m2_q;
        in_pkt_d   = acc ? !src.t_last : in_pkt_q;
        mode_lat_d = (acc && !in_pkt_q) ? mode_e'(mode) : mode_lat_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            l0_q       <= 1'b0;
            l1_q       <= 1'b0;
            l2_q       <= 1'b0;
            l3_q       <= 1'b0;
            m0_q       <= MODE_601L;
            m1_q       <= MODE_601L;
            m2_q       <= MODE_601L;
            in_pkt_q   <= 1'b0;
            mode_lat_q <= MODE_601L;
        end else begin
            v0_q       <= v0_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            v3_q       <= v3_d;
            l0_q       <= l0_d;
            l1_q       <= l1_d;
            l2_q       <= l2_d;
            l3_q       <= l3_d;
            m0_q       <= m0_d;
            m1_q       <= m1_d;
            m2_q       <= m2_d;
            in_pkt_q   <= in_pkt_d;
            mode_lat_q <= mode_lat_d;
        end
    end

    for (genvar p = 0; p < PIXELS; p++) begin : g_pix
        yuv_rgb_pixel_dp #(
            .FRAC(FRAC)
        ) u_dp (
            .clk    (clk),
            .rst    (rst),
            .en0    (acc),
            .en1    (adv0),
            .en2    (adv1),
            .en3    (adv2),
            .mode_in(beat_mode),
            .mode_s0(m0_q),
            .mode_s2(m2_q),
            .pix_in (src.t_data[32*p +: 24]),
            .pix_out(out_data[32*p +: 32])
        );
    end

    always_comb begin
        unused_sig = ^{src.t_id, src.t_dest, src.t_user,
                       src.t_keep, src.t_strb};
        for (int p = 0; p < PIXELS; p++) begin
            unused_sig = unused_sig ^ (^src.t_data[32*p+PAD_LSB +: 8]);
        end
    end

    assign src.t_ready = src_rdy;
    assign dst.t_valid = v3_q;
    assign dst.t_last  = l3_q;
    assign dst.t_data  = out_data;
    assign dst.t_strb  = '1;
    assign dst.t_keep  = '1;
    assign dst.t_dest  = '0;
    assign dst.t_id    = '0;
    assign dst.t_user  = '0;
    assign busy        = v0_q | v1_q | v2_q | v3_q;

    a_keep_strb: assert property (
        @(posedge clk) disable iff (!rst)
        acc |-> (&src.t_keep && &src.t_strb)
    ) else $error("yuv444_rgb_stream_conv: src t_keep/t_strb not all ones");

endmodule

// File: tb/tb_yuv444_rgb_stream_conv.sv
// Bench for yuv444_rgb_stream_conv: directed beats with literal results
// plus a per-cycle scoreboard built from the colour equations.
`timescale 1ns/1ps
module tb_yuv444_rgb_stream_conv;

    localparam int PIXELS = 2;
    localparam int DW     = 32*PIXELS;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       busy;

    nasti_stream_channel #(.N_DATA_BITS(DW)) src_if();
    nasti_stream_channel #(.N_DATA_BITS(DW)) dst_if();

    yuv444_rgb_stream_conv #(
        .PIXELS(PIXELS),
        .FRAC  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mode(mode),
        .src (src_if.slave),
        .dst (dst_if.master),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int max_run = 0;
    bit bp_en = 1'b0;
    logic rdy_fix = 1'b1;
    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    function automatic int clip(input int x);
        return (x < 0) ? 0 : ((x > 255) ? 255 : x);
    endfunction

    function automatic logic [31:0] conv_px(input logic [1:0] m,
                                            input logic [31:0] px);
        int y, u, v, c, d, e, r, g, b;
        int cy, rv, gu, gv, bu;
        logic [7:0] r8, g8, b8;
        y = int'(px[15:8]);
        u = int'(px[7:0]);
        v = int'(px[23:16]);
        cy = 298; rv = 409; gu = 100; gv = 208; bu = 516;
        if (m == 2'd1) begin
            rv = 459; gu = 55; gv = 136; bu = 541;
        end
        if (m == 2'd2) begin
            cy = 256; rv = 359; gu = 88; gv = 183; bu = 454;
        end
        c = (m == 2'd2) ? y : y - 16;
        d = u - 128;
        e = v - 128;
        r = (cy*c + rv*e + 128) >>> 8;
        g = (cy*c - gu*d - gv*e + 128) >>> 8;
        b = (cy*c + bu*d + 128) >>> 8;
        r8 = 8'(clip(r));
        g8 = 8'(clip(g));
        b8 = 8'(clip(b));
        if (m == 2'd3) return {8'h00, px[23:0]};
        return {8'h00, b8, g8, r8};
    endfunction

    function automatic logic [DW-1:0] conv_beat(input logic [1:0] m,
                                                input logic [DW-1:0] dat);
        logic [DW-1:0] o;
        o = '0;
        for (int p = 0; p < PIXELS; p++) begin
            o[32*p +: 32] = conv_px(m, dat[32*p +: 32]);
        end
        return o;
    endfunction

    // scoreboard: occupancy, ordering, data and t_last on every cycle
    initial begin
        bit         in_pkt;
        logic [1:0] pkt_mode, pm;
        int         run_len;
        in_pkt   = 1'b0;
        pkt_mode = 2'd0;
        run_len  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                exp_last_q.delete();
                in_pkt  = 1'b0;
                run_len = 0;
            end else begin
                chk("src_ready", src_if.t_ready,
                    !(exp_q.size() == 4 && !dst_if.t_ready));
                chk("busy", busy, exp_q.size() != 0);
                chk("valid_without_beat",
                    dst_if.t_valid && exp_q.size() == 0, 0);
                if (dst_if.t_valid && dst_if.t_ready) begin
                    if (exp_q.size() != 0) begin
                        chk("dst_data", dst_if.t_data, exp_q.pop_front());
                        chk("dst_last", dst_if.t_last,
                            exp_last_q.pop_front());
                    end
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else begin
                    run_len = 0;
                end
                if (src_if.t_valid && src_if.t_ready) begin
                    pm = in_pkt ? pkt_mode : mode;
                    if (!in_pkt) pkt_mode = mode;
                    exp_q.push_back(conv_beat(pm, src_if.t_data));
                    exp_last_q.push_back(src_if.t_last);
                    in_pkt = !src_if.t_last;
                end
            end
        end
    end

    initial begin
        dst_if.t_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dst_if.t_ready = bp_en ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    task automatic send_beat(input logic [DW-1:0] data, input logic last,
                             output int tries);
        bit r;
        src_if.t_valid = 1'b1;
        src_if.t_data  = data;
        src_if.t_last  = last;
        tries = 0;
        do begin
            @(negedge clk);
            r = src_if.t_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!r && tries < 200);
        chk("src_accept", r, 1);
        src_if.t_valid = 1'b0;
    endtask

    task automatic send_one(input string name, input logic [1:0] m,
                            input logic [DW-1:0] data,
                            input logic [DW-1:0] want);
        int t, k;
        mode = m;
        send_beat(data, 1'b1, t);
        k = 1;
        while (!dst_if.t_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({name, "_latency"}, k, 4);
        chk({name, "_last"}, dst_if.t_last, 1);
        chk({name, "_data"}, dst_if.t_data, want);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int t, stale;
        logic [DW-1:0] grey;
        grey = {32'h00808080, 32'h00808080};
        src_if.t_valid = 1'b0;
        src_if.t_data  = '0;
        src_if.t_last  = 1'b0;
        src_if.t_strb  = '1;
        src_if.t_keep  = '1;
        src_if.t_id    = '0;
        src_if.t_dest  = '0;
        src_if.t_user  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", dst_if.t_valid, 0);
        chk("rst_last", dst_if.t_last, 0);
        chk("rst_data", dst_if.t_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strb", dst_if.t_strb, 8'hFF);
        chk("rst_dest", dst_if.t_dest, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        chk("model_601l_red", conv_px(2'd0, 32'h00F0515A), 32'h000000FF);
        chk("model_601l_zero", conv_px(2'd0, 32'h00000000), 32'h00008700);
        chk("model_601l_grey", conv_px(2'd0, 32'h00808080), 32'h00828282);
        chk("model_601f_grey", conv_px(2'd2, 32'h00808080), 32'h00808080);

        send_one("white_black", 2'd0, {32'h00801080, 32'h0080EB80},
                 {32'h00000000, 32'h00FFFFFF});
        send_one("red_clamp", 2'd0, {32'h00FFFF80, 32'h00F0515A},
                 {32'h00FFAFFF, 32'h000000FF});
        send_one("full_range", 2'd2, {32'h00000000, 32'h00808080},
                 {32'h00008800, 32'h00808080});
        send_one("bypass", 2'd3, {32'hAABBCCDD, 32'h11223344},
                 {32'h00BBCCDD, 32'h00223344});
        send_one("zero_clamp", 2'd0, {32'h0080EB80, 32'h00000000},
                 {32'h00FFFFFF, 32'h00008700});
        send_one("bt709", 2'd1, {32'h00F0515A, 32'h00808080},
                 {32'h000018FF, 32'h00828282});

        bp_en = 1'b1;
        mode  = 2'd0;
        for (int i = 0; i < 16; i++) begin
            send_beat({$urandom, $urandom}, i == 15, t);
        end
        bp_en   = 1'b0;
        rdy_fix = 1'b1;
        drain("backpressure");

        @(posedge clk);
        #1;
        max_run = 0;
        mode = 2'd1;
        for (int i = 0; i < 8; i++) begin
            send_beat({$urandom, $urandom}, i == 7, t);
            chk("tput_accept_cycles", t, 1);
        end
        drain("throughput");
        chk("tput_run", max_run, 8);

        mode = 2'd0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) mode = 2'd2;
            send_beat(grey, i == 7, t);
        end
        for (int i = 0; i < 4; i++) begin
            send_beat(grey, i == 3, t);
        end
        drain("mode_switch");

        rdy_fix = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mode = 2'd1;
        for (int i = 0; i < 3; i++) begin
            send_beat({$urandom, $urandom}, 1'b0, t);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_valid", dst_if.t_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", dst_if.t_valid, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        rdy_fix = 1'b1;
        mode    = 2'd2;
        stale   = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (dst_if.t_valid) stale++;
        end
        chk("no_stale_beats", stale, 0);
        send_one("post_rst_mode", 2'd2, grey, grey);
        drain("final");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule
